cordic_ci_ctrl: RTL and testbench
=================================

Name: cordic_ci_ctrl

Overview:
- Custom-instruction front end sitting directly upstream of the iterative CORDIC cosine core.
- Accepts the processor's clk_en/start/dataa handshake and launches the core.
- Gates the core's clock enable, watches core_done, then captures and holds the result and pulses done.
- A one-entry result cache answers repeated arguments (sign-insensitive, cos is even) without running the core.

Parameters:
- UNROLLS, 2: rotations per core cycle; informational only, sets the expected latency.
- ITERS, 16: total core rotations; expected run length N = ITERS/UNROLLS.
- TIMEOUT, 32: maximum RUN cycles before the watchdog aborts.
- ERR_RESULT, 32'h7FC00000: value returned on a watchdog abort (quiet NaN).
- CACHE_EN, 1: 1 enables the result cache; 0 treats every request as a miss.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- clk_en  in  1  processor clock-enable; low freezes all controller state.
- start  in  1  request strobe, qualified by clk_en.
- dataa  in  32  IEEE-754 single-precision argument.
- result  out  32  held result.
- done  out  1  high while the FSM is in DONE.
- busy  out  1  high in INIT, LAUNCH, RUN and DONE.
- err  out  1  sticky flag; set on watchdog abort, cleared only by reset.
- core_aclr  out  1  synchronous clear to the core (active-high).
- core_clk_en  out  1  core clock-enable.
- core_start  out  1  core load strobe.
- core_dataa  out  32  registered argument to the core.
- core_result  in  32  core FP output.
- core_done  in  1  core terminal-count flag (combinational from the core's index register).

Behaviour:
- Reset (aclr_n low, asynchronous):
  - FSM goes to INIT.
  - result=0, core_dataa=0, cache_valid=0, cache_key=0, cache_val=0, err=0, watchdog=0.
  - done=0, core_start=0, core_clk_en=0, core_aclr=1.
- States are INIT, IDLE, LAUNCH, RUN, DONE. When clk_en=0, no register changes and core_clk_en=0.
- INIT: core_aclr=1 for one enabled cycle, then IDLE. A start seen in INIT is ignored.
- IDLE, on start=1:
  - Hit, when CACHE_EN=1 && cache_valid && dataa[30:0]==cache_key: result<=cache_val; go to DONE.
  - Miss: core_dataa<=dataa; go to LAUNCH.
- LAUNCH: core_start=1, core_clk_en=1; watchdog<=0; go to RUN.
- RUN, all outputs combinational from state and inputs:
  - core_clk_en = !core_done; core_start=0.
  - If core_done=1: result<=core_result; cache_key<=core_dataa[30:0]; cache_val<=core_result; cache_valid<=1; go to DONE. The core freezes at terminal count.
  - Else watchdog increments. When watchdog reaches TIMEOUT-1 without core_done: result<=ERR_RESULT; err<=1; cache_valid<=0; go to DONE.
- DONE: done=1 for exactly one enabled cycle, then IDLE. If clk_en is low, done stays high.
- Outside LAUNCH and RUN: core_clk_en=0 and core_start=0.
- Latency, with cycle 0 as the edge that samples start:
  - Miss: LAUNCH in cycle 1, RUN in cycles 2..N+2, done in cycle N+3 (11 for defaults).
  - Hit: done in cycle 1.
- result holds its value until the next capture or reset.
- start while busy (outside IDLE) is ignored and causes no state change.
- Reset mid-operation: the core is cleared via INIT; the cache is invalidated.
- Width rules:
  - The cache key drops the sign bit, so -x hits on a cached +x.
  - watchdog is clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
- Reset, then start with dataa=32'h3F800000 (1.0) -> core_start high in cycle 1; done pulse in cycle 11; result = core_result (~32'h3F0A5140); busy low in cycle 12.
- Repeat with dataa=32'hBF800000 (-1.0) -> cache hit; done in cycle 1; core_clk_en stays 0; same result.
- Miss with clk_en held low for 3 cycles during RUN -> no state change while low; done arrives 3 cycles late (cycle 14); result correct.
- Core model that never asserts core_done -> done at cycle 2+TIMEOUT=34; result=32'h7FC00000; err=1 and stays 1 after later successful calls.
- aclr_n pulsed low in cycle 5 of a run -> done=0, result=0 immediately; core_aclr=1 in the first enabled cycle after release; next identical dataa is a miss (11-cycle latency).
- Second start issued in cycle 4 of a run -> ignored; only one done pulse; core_dataa unchanged.

Source files
------------

// File: rtl/cordic_ci_ctrl.sv
// Custom-instruction front end for the iterative CORDIC cosine core:
// launches the core, watches for completion or timeout, and caches the last result.
module cordic_ci_ctrl #(
    parameter int          UNROLLS    = 2,
    parameter int          ITERS      = 16,
    parameter int          TIMEOUT    = 32,
    parameter logic [31:0] ERR_RESULT = 32'h7FC00000,
    parameter bit          CACHE_EN   = 1'b1
) (
    input  logic        clock,
    input  logic        aclr_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        core_aclr,
    output logic        core_clk_en,
    output logic        core_start,
    output logic [31:0] core_dataa,
    input  logic [31:0] core_result,
    input  logic        core_done
);

    localparam int N    = ITERS / UNROLLS;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    // A watchdog no longer than the nominal run would abort every request.
    if (TIMEOUT <= N + 1) begin : g_bad_timeout
        $error("cordic_ci_ctrl: TIMEOUT must exceed the core run length");
    end

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       dataa_q, dataa_d;
    logic              cvalid_q, cvalid_d;
    logic [30:0]       ckey_q, ckey_d;
    logic [31:0]       cval_q, cval_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              hit;

    assign hit = CACHE_EN && cvalid_q && (dataa[30:0] == ckey_q);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= S_INIT;
            result_q <= '0;
            dataa_q  <= '0;
            cvalid_q <= 1'b0;
            ckey_q   <= '0;
            cval_q   <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            result_q <= result_d;
            dataa_q  <= dataa_d;
            cvalid_q <= cvalid_d;
            ckey_q   <= ckey_d;
            cval_q   <= cval_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        dataa_d     = dataa_q;
        cvalid_d    = cvalid_q;
        ckey_d      = ckey_q;
        cval_d      = cval_q;
        err_d       = err_q;
        wd_d        = wd_q;
        core_aclr   = 1'b0;
        core_clk_en = 1'b0;
        core_start  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                core_aclr = 1'b1;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                if (start) begin
                    if (hit) begin
                        result_d = cval_q;
                        state_d  = S_DONE;
                    end else begin
                        dataa_d = dataa;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                core_start  = 1'b1;
                core_clk_en = 1'b1;
                wd_d        = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                core_clk_en = !core_done;
                if (core_done) begin
                    result_d = core_result;
                    ckey_d   = dataa_q[30:0];
                    cval_d   = core_result;
                    cvalid_d = 1'b1;
                    state_d  = S_DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    result_d = ERR_RESULT;
                    err_d    = 1'b1;
                    cvalid_d = 1'b0;
                    state_d  = S_DONE;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        // A frozen processor must also freeze the core.
        if (!clk_en) begin
            core_clk_en = 1'b0;
        end
    end

    assign result     = result_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign core_dataa = dataa_q;

endmodule

// File: tb/tb_cordic_ci_ctrl.sv
// Bench for cordic_ci_ctrl: behavioural core model, vector table and
// hand-written reset / busy-start sequences with a result scoreboard.
module tb_cordic_ci_ctrl;

    localparam int          N       = 8;
    localparam logic [31:0] ERR_VAL = 32'h7FC00000;

    logic        clock = 1'b0;
    logic        aclr_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err;
    logic        core_aclr;
    logic        core_clk_en;
    logic        core_start;
    logic [31:0] core_dataa;
    logic [31:0] core_result;
    logic        core_done;

    logic        core_hang = 1'b0;
    int          c_idx;
    logic        c_loaded;
    logic [31:0] c_arg;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];

    cordic_ci_ctrl dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .clk_en     (clk_en),
        .start      (start),
        .dataa      (dataa),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .err        (err),
        .core_aclr  (core_aclr),
        .core_clk_en(core_clk_en),
        .core_start (core_start),
        .core_dataa (core_dataa),
        .core_result(core_result),
        .core_done  (core_done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] cos_model(input logic [31:0] a);
        if (a[30:0] == 31'h3F800000) return 32'h3F0A5140;
        return {1'b0, a[30:0] ^ 31'h005A5A5A};
    endfunction

    // Iterative core: loads on core_start, steps while enabled, freezes at N.
    always @(posedge clock) begin
        if (core_aclr) begin
            c_idx    <= 0;
            c_loaded <= 1'b0;
            c_arg    <= '0;
        end else if (core_clk_en) begin
            if (core_start) begin
                c_idx    <= 0;
                c_loaded <= 1'b1;
                c_arg    <= core_dataa;
            end else if (c_idx < N) begin
                c_idx <= c_idx + 1;
            end
        end
    end

    assign core_done   = c_loaded && (c_idx == N) && !core_hang;
    assign core_result = cos_model(c_arg);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input int stall_at,
                          input int stall_len, input int budget,
                          output int lat, output logic cs1,
                          output logic cke_seen, output logic busy_after,
                          output logic done_after);
        int k;
        @(negedge clock);
        start    = 1'b1;
        dataa    = a;
        lat      = -1;
        cs1      = 1'b0;
        cke_seen = 1'b0;
        k        = 0;
        while (k < budget) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            if (k == 1) cs1 = core_start;
            if (core_clk_en) cke_seen = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            clk_en = !(k >= stall_at && k < stall_at + stall_len);
        end
        clk_en = 1'b1;
        @(negedge clock);
        busy_after = busy;
        done_after = done;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        hang;
        int          stall_at;
        int          stall_len;
        int          lat;
        logic        hit;
        logic        err;
    } vec_t;

    vec_t vec[6];

    initial begin
        int          lat;
        logic        cs1, cke, b_after, d_after;
        logic [31:0] exp_r;
        logic [31:0] a1;
        int          ndone, done_k;
        logic        cdata_ok;

        vec[0] = '{32'h3F800000, 1'b0, 0, 0, 11, 1'b0, 1'b0};
        vec[1] = '{32'hBF800000, 1'b0, 0, 0, 1,  1'b1, 1'b0};
        vec[2] = '{32'h40000000, 1'b0, 5, 3, 14, 1'b0, 1'b0};
        vec[3] = '{32'h40400000, 1'b1, 0, 0, 34, 1'b0, 1'b1};
        vec[4] = '{32'h40000000, 1'b0, 0, 0, 11, 1'b0, 1'b1};
        vec[5] = '{32'hC0000000, 1'b0, 0, 0, 1,  1'b1, 1'b1};

        aclr_n = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        repeat (2) @(negedge clock);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_core_aclr", {31'b0, core_aclr}, 32'd1);
        chk("rst_core_cke", {31'b0, core_clk_en}, 32'd0);
        chk("rst_core_start", {31'b0, core_start}, 32'd0);
        chk("rst_core_dataa", core_dataa, 32'd0);
        aclr_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            core_hang = vec[i].hang;
            sb_q.push_back(vec[i].hang ? ERR_VAL : cos_model(vec[i].a));
            do_req(vec[i].a, vec[i].stall_at, vec[i].stall_len, 60,
                   lat, cs1, cke, b_after, d_after);
            core_hang = 1'b0;
            exp_r = sb_q.pop_front();
            if (lat < 0) begin
                errors++;
                checks++;
                $display("FAIL v%0d_timeout: no done within budget", i);
            end else begin
                chk($sformatf("v%0d_latency", i), lat, vec[i].lat);
                chk($sformatf("v%0d_result", i), result, exp_r);
            end
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vec[i].err});
            chk($sformatf("v%0d_core_start_c1", i), {31'b0, cs1},
                {31'b0, !vec[i].hit});
            chk($sformatf("v%0d_core_cke_seen", i), {31'b0, cke},
                {31'b0, !vec[i].hit});
            chk($sformatf("v%0d_busy_after", i), {31'b0, b_after}, 32'd0);
            chk($sformatf("v%0d_done_pulse", i), {31'b0, d_after}, 32'd0);
        end

        // Asynchronous reset in cycle 5 of a run.
        @(negedge clock);
        start = 1'b1;
        dataa = 32'h3F000000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            start = 1'b0;
        end
        aclr_n = 1'b0;
        #1;
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_core_cke", {31'b0, core_clk_en}, 32'd0);
        @(negedge clock);
        aclr_n = 1'b1;
        #1;
        chk("post_rst_core_aclr", {31'b0, core_aclr}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd1);
        sb_q.push_back(cos_model(32'h40000000));
        do_req(32'h40000000, 0, 0, 60, lat, cs1, cke, b_after, d_after);
        exp_r = sb_q.pop_front();
        chk("post_rst_miss_latency", lat, 32'd11);
        chk("post_rst_result", result, exp_r);

        // Second start while running must be ignored.
        a1 = 32'h3F800000;
        sb_q.push_back(cos_model(a1));
        @(negedge clock);
        start    = 1'b1;
        dataa    = a1;
        ndone    = 0;
        done_k   = -1;
        cdata_ok = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clock);
            if (core_dataa !== a1) cdata_ok = 1'b0;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            start = (k == 4);
            dataa = (k == 4) ? 32'h40800000 : a1;
        end
        exp_r = sb_q.pop_front();
        chk("busy_start_done_count", ndone, 32'd1);
        chk("busy_start_latency", done_k, 32'd11);
        chk("busy_start_core_dataa", {31'b0, cdata_ok}, 32'd1);
        chk("busy_start_result", result, exp_r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
